// File: rtl/lsq_commit.sv
// Load/store queue: in-order memory issue from the head, CDB/load-result wake-up,
// early store-ready report to the ROB, and store drain only after ROB commit.
//
// state | meaning
// IDLE  | waiting for the head entry to become issuable
// REQ   | memory request held stable until mem_ack
// WAIT  | load accepted, waiting for mem_rvalid
// DRAIN | load flushed after acceptance, its return data is discarded

module lsq_commit #(
    parameter int          DEPTH     = 8,
    parameter int          ROB_BITS  = 4,
    parameter int          CDB_PORTS = 2,
    parameter logic [31:0] MMIO_BASE = 32'h00030000
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    output logic                          lsq_full,
    input  logic                          enq_valid,
    input  logic [5:0]                    enq_op,
    input  logic [31:0]                   enq_vj,
    input  logic [31:0]                   enq_vk,
    input  logic [31:0]                   enq_imm,
    input  logic [ROB_BITS-1:0]           enq_qj,
    input  logic [ROB_BITS-1:0]           enq_qk,
    input  logic                          enq_j,
    input  logic                          enq_k,
    input  logic [ROB_BITS-1:0]           enq_rob,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*ROB_BITS-1:0] cdb_tag,
    input  logic [CDB_PORTS*32-1:0]       cdb_value,
    input  logic [ROB_BITS-1:0]           rob_head,
    input  logic                          commit_valid,
    input  logic [ROB_BITS-1:0]           commit_rob,
    input  logic                          flush,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [2:0]                    mem_width,
    output logic [31:0]                   mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic                          mem_ack,
    input  logic                          mem_rvalid,
    input  logic [31:0]                   mem_rdata,
    output logic                          ld_valid,
    output logic [ROB_BITS-1:0]           ld_rob,
    output logic [31:0]                   ld_value,
    output logic                          st_ready,
    output logic [ROB_BITS-1:0]           st_rob
);

    localparam int PW = $clog2(DEPTH);
    localparam int NS = CDB_PORTS + 1;
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    localparam logic [5:0] OP_LB  = 6'd10;
    localparam logic [5:0] OP_LH  = 6'd11;
    localparam logic [5:0] OP_LBU = 6'd13;
    localparam logic [5:0] OP_LHU = 6'd14;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [PW:0]         count_q, count_d;
    logic [DEPTH-1:0]    busy_q, busy_d, cmt_q, cmt_d, rep_q, rep_d, j_q, j_d, k_q, k_d;
    logic [5:0]          op_q  [DEPTH];
    logic [5:0]          op_d  [DEPTH];
    logic [31:0]         vj_q  [DEPTH];
    logic [31:0]         vj_d  [DEPTH];
    logic [31:0]         vk_q  [DEPTH];
    logic [31:0]         vk_d  [DEPTH];
    logic [31:0]         imm_q [DEPTH];
    logic [31:0]         imm_d [DEPTH];
    logic [ROB_BITS-1:0] qj_q  [DEPTH];
    logic [ROB_BITS-1:0] qj_d  [DEPTH];
    logic [ROB_BITS-1:0] qk_q  [DEPTH];
    logic [ROB_BITS-1:0] qk_d  [DEPTH];
    logic [ROB_BITS-1:0] rob_q [DEPTH];
    logic [ROB_BITS-1:0] rob_d [DEPTH];

    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [2:0]          mem_width_q, mem_width_d;
    logic [31:0]         mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic                ld_valid_q, ld_valid_d, st_ready_q, st_ready_d;
    logic [ROB_BITS-1:0] ld_rob_q, ld_rob_d, st_rob_q, st_rob_d;
    logic [31:0]         ld_value_q, ld_value_d;

    logic [NS-1:0]          src_valid;
    logic [NS*ROB_BITS-1:0] src_tag;
    logic [NS*32-1:0]       src_val;
    logic [PW-1:0]          hd, idx;
    logic [31:0]            hd_addr;
    logic [32:0]            sn;
    logic [PW:0]            ccount;
    logic                   pop, found, enq_fire, hd_store;

    function automatic logic is_store(input logic [5:0] op);
        return op >= OP_SB;
    endfunction

    function automatic logic [2:0] op_width(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] st_data(input logic [5:0] op, input logic [31:0] v);
        case (op)
            OP_SB:   return {24'b0, v[7:0]};
            OP_SH:   return {16'b0, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [31:0] ld_ext(input logic [5:0] op, input logic [31:0] d);
        case (op)
            OP_LB:   return {{24{d[7]}}, d[7:0]};
            OP_LH:   return {{16{d[15]}}, d[15:0]};
            OP_LBU:  return {24'b0, d[7:0]};
            OP_LHU:  return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Scans from the highest source down so the lowest-numbered match wins.
    function automatic logic [32:0] snoop(input logic [ROB_BITS-1:0] tag,
                                          input logic [NS-1:0] v,
                                          input logic [NS*ROB_BITS-1:0] t,
                                          input logic [NS*32-1:0] d);
        logic [32:0] r;
        r = '0;
        for (int s = NS - 1; s >= 0; s--)
            if (v[s] && t[s*ROB_BITS +: ROB_BITS] == tag) r = {1'b1, d[s*32 +: 32]};
        return r;
    endfunction

    assign src_valid = {ld_valid_q, cdb_valid};
    assign src_tag   = {ld_rob_q, cdb_tag};
    assign src_val   = {ld_value_q, cdb_value};
    assign lsq_full  = (count_q == FULL_CNT);

    always_comb begin
        state_d = state_q;   head_d = head_q;   tail_d = tail_q;   count_d = count_q;
        busy_d = busy_q;     cmt_d = cmt_q;     rep_d = rep_q;     j_d = j_q;   k_d = k_q;
        op_d = op_q;   vj_d = vj_q;   vk_d = vk_q;   imm_d = imm_q;
        qj_d = qj_q;   qk_d = qk_q;   rob_d = rob_q;
        mem_req_d = mem_req_q;     mem_we_d = mem_we_q;       mem_width_d = mem_width_q;
        mem_addr_d = mem_addr_q;   mem_wdata_d = mem_wdata_q;
        ld_valid_d = 1'b0;   ld_rob_d = ld_rob_q;   ld_value_d = ld_value_q;
        st_ready_d = 1'b0;   st_rob_d = st_rob_q;
        pop = 1'b0;   found = 1'b0;   ccount = '0;   idx = '0;   sn = '0;
        hd = head_q;
        hd_store = is_store(op_q[hd]);
        hd_addr = vj_q[hd] + imm_q[hd];
        enq_fire = enq_valid && !lsq_full && !flush;

        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && !j_q[i]) begin
                sn = snoop(qj_q[i], src_valid, src_tag, src_val);
                if (sn[32]) begin j_d[i] = 1'b1; vj_d[i] = sn[31:0]; end
            end
            if (busy_q[i] && !k_q[i]) begin
                sn = snoop(qk_q[i], src_valid, src_tag, src_val);
                if (sn[32]) begin k_d[i] = 1'b1; vk_d[i] = sn[31:0]; end
            end
            if (commit_valid && busy_q[i] && is_store(op_q[i]) && rob_q[i] == commit_rob)
                cmt_d[i] = 1'b1;
            if (busy_q[i] && cmt_d[i]) ccount = ccount + 1'b1;
        end

        for (int n = 0; n < DEPTH; n++) begin
            idx = head_q + PW'(n);
            if (!found && busy_q[idx] && is_store(op_q[idx]) && j_q[idx] && k_q[idx] &&
                !rep_q[idx] && (!flush || cmt_d[idx])) begin
                found = 1'b1;   rep_d[idx] = 1'b1;
                st_ready_d = 1'b1;   st_rob_d = rob_q[idx];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (busy_q[hd] && j_q[hd] && k_q[hd] &&
                    (hd_store ? cmt_q[hd]
                              : (!flush && (hd_addr < MMIO_BASE || rob_head == rob_q[hd])))) begin
                    state_d = S_REQ;   mem_req_d = 1'b1;   mem_we_d = hd_store;
                    mem_width_d = op_width(op_q[hd]);
                    mem_addr_d = hd_addr;
                    mem_wdata_d = hd_store ? st_data(op_q[hd], vk_q[hd]) : 32'b0;
                end
            end
            S_REQ: begin
                // Committed stores ignore flush; loads abandon or drain.
                if (mem_we_q) begin
                    if (mem_ack) begin pop = 1'b1; mem_req_d = 1'b0; state_d = S_IDLE; end
                end else if (flush) begin
                    mem_req_d = 1'b0;
                    state_d = mem_ack ? S_DRAIN : S_IDLE;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;   state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                    if (!flush) begin
                        pop = 1'b1;   ld_valid_d = 1'b1;   ld_rob_d = rob_q[hd];
                        ld_value_d = ld_ext(op_q[hd], mem_rdata);
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (mem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (pop) begin busy_d[hd] = 1'b0; cmt_d[hd] = 1'b0; rep_d[hd] = 1'b0; end
        head_d = head_q + PW'(pop);

        if (enq_fire) begin
            busy_d[tail_q] = 1'b1;   cmt_d[tail_q] = 1'b0;   rep_d[tail_q] = 1'b0;
            op_d[tail_q] = enq_op;   imm_d[tail_q] = enq_imm;   rob_d[tail_q] = enq_rob;
            qj_d[tail_q] = enq_qj;   qk_d[tail_q] = enq_qk;
            sn = snoop(enq_qj, src_valid, src_tag, src_val);
            j_d[tail_q]  = enq_j | sn[32];
            vj_d[tail_q] = (enq_j || !sn[32]) ? enq_vj : sn[31:0];
            sn = snoop(enq_qk, src_valid, src_tag, src_val);
            k_d[tail_q]  = enq_k | sn[32];
            vk_d[tail_q] = (enq_k || !sn[32]) ? enq_vk : sn[31:0];
            tail_d = tail_q + PW'(1);
        end

        if (flush) begin
            busy_d = busy_d & cmt_d;
            tail_d = head_q + ccount[PW-1:0];
            count_d = ccount - (PW+1)'(pop);
        end else begin
            count_d = count_q + (PW+1)'(enq_fire) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;   head_q <= '0;   tail_q <= '0;   count_q <= '0;
            busy_q <= '0;   cmt_q <= '0;   rep_q <= '0;   j_q <= '0;   k_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i] <= '0;   vj_q[i] <= '0;   vk_q[i] <= '0;   imm_q[i] <= '0;
                qj_q[i] <= '0;   qk_q[i] <= '0;   rob_q[i] <= '0;
            end
            mem_req_q <= 1'b0;   mem_we_q <= 1'b0;   mem_width_q <= '0;
            mem_addr_q <= '0;    mem_wdata_q <= '0;
            ld_valid_q <= 1'b0;  ld_rob_q <= '0;     ld_value_q <= '0;
            st_ready_q <= 1'b0;  st_rob_q <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;  head_q <= head_d;   tail_q <= tail_d;   count_q <= count_d;
            busy_q <= busy_d;    cmt_q <= cmt_d;     rep_q <= rep_d;     j_q <= j_d;   k_q <= k_d;
            op_q <= op_d;   vj_q <= vj_d;   vk_q <= vk_d;   imm_q <= imm_d;
            qj_q <= qj_d;   qk_q <= qk_d;   rob_q <= rob_d;
            mem_req_q <= mem_req_d;     mem_we_q <= mem_we_d;     mem_width_q <= mem_width_d;
            mem_addr_q <= mem_addr_d;   mem_wdata_q <= mem_wdata_d;
            ld_valid_q <= ld_valid_d;   ld_rob_q <= ld_rob_d;     ld_value_q <= ld_value_d;
            st_ready_q <= st_ready_d;   st_rob_q <= st_rob_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_width = mem_width_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ld_valid  = ld_valid_q;
    assign ld_rob    = ld_rob_q;
    assign ld_value  = ld_value_q;
    assign st_ready  = st_ready_q;
    assign st_rob    = st_rob_q;

endmodule

// File: tb/tb_lsq_commit.sv
// Directed bench for lsq_commit: loads, wake-up, commit-gated stores, full/wrap,
// MMIO ordering, flush, load-result bypass and mid-request reset.

module tb_lsq_commit;

    localparam logic [5:0] LB = 6'd10, LH = 6'd11, LW = 6'd12, LBU = 6'd13;
    localparam logic [5:0] SH = 6'd16, SW = 6'd17;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1, rdy_in = 1'b1, lsq_full;
    logic        enq_valid = 1'b0, enq_j = 1'b0, enq_k = 1'b0;
    logic [5:0]  enq_op = '0;
    logic [31:0] enq_vj = '0, enq_vk = '0, enq_imm = '0;
    logic [3:0]  enq_qj = '0, enq_qk = '0, enq_rob = '0;
    logic [1:0]  cdb_valid = '0;
    logic [7:0]  cdb_tag = '0;
    logic [63:0] cdb_value = '0;
    logic [3:0]  rob_head = '0, commit_rob = '0;
    logic        commit_valid = 1'b0, flush = 1'b0;
    logic        mem_req, mem_we, mem_ack = 1'b0, mem_rvalid = 1'b0;
    logic [2:0]  mem_width;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic        ld_valid, st_ready;
    logic [3:0]  ld_rob, st_rob;
    logic [31:0] ld_value;

    int vectors = 0;
    int miscompares = 0;

    lsq_commit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .lsq_full(lsq_full),
        .enq_valid(enq_valid), .enq_op(enq_op), .enq_vj(enq_vj), .enq_vk(enq_vk),
        .enq_imm(enq_imm), .enq_qj(enq_qj), .enq_qk(enq_qk), .enq_j(enq_j), .enq_k(enq_k),
        .enq_rob(enq_rob), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rob_head(rob_head), .commit_valid(commit_valid), .commit_rob(commit_rob),
        .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ld_valid(ld_valid),
        .ld_rob(ld_rob), .ld_value(ld_value), .st_ready(st_ready), .st_rob(st_rob)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic [3:0] qj, input logic [3:0] qk,
                       input logic j, input logic k, input logic [3:0] rob);
        enq_valid = 1'b1;  enq_op = op;  enq_vj = vj;  enq_vk = vk;  enq_imm = imm;
        enq_qj = qj;  enq_qk = qk;  enq_j = j;  enq_k = k;  enq_rob = rob;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 10) begin
            tick();
            n++;
        end
        chk(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic commit(input logic [3:0] rob);
        commit_valid = 1'b1;  commit_rob = rob;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic ack();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic rdata(input logic [31:0] d);
        mem_rvalid = 1'b1;  mem_rdata = d;
        tick();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst_in = 1'b0;
        chk("rst_full", 32'(lsq_full), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_ldv", 32'(ld_valid), 32'd0);
        chk("rst_str", 32'(st_ready), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);

        // Basic LB: sign-extended byte
        enq(LB, 32'h100, 32'h0, 32'd4, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1);
        chk("lb_noreq", 32'(mem_req), 32'd0);
        tick();
        chk("lb_req", 32'(mem_req), 32'd1);
        chk("lb_addr", mem_addr, 32'h104);
        chk("lb_width", 32'(mem_width), 32'd1);
        chk("lb_we", 32'(mem_we), 32'd0);
        ack();
        chk("lb_req_drop", 32'(mem_req), 32'd0);
        rdata(32'h80);
        chk("lb_ldv", 32'(ld_valid), 32'd1);
        chk("lb_val", ld_value, 32'hFFFFFF80);
        chk("lb_rob", 32'(ld_rob), 32'd1);
        tick();
        chk("lb_pulse", 32'(ld_valid), 32'd0);

        // LBU with an rdy_in stall while ack is offered
        enq(LBU, 32'h100, 32'h0, 32'd4, 4'd0, 4'd0, 1'b1, 1'b1, 4'd2);
        tick();
        chk("lbu_req", 32'(mem_req), 32'd1);
        rdy_in = 1'b0;  mem_ack = 1'b1;
        tick();
        chk("lbu_frozen", 32'(mem_req), 32'd1);
        rdy_in = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("lbu_req_drop", 32'(mem_req), 32'd0);
        rdata(32'h80);
        chk("lbu_ldv", 32'(ld_valid), 32'd1);
        chk("lbu_val", ld_value, 32'h00000080);
        tick();

        // SW woken by CDB port 1, drains only after commit
        enq(SW, 32'h200, 32'h0, 32'h0, 4'd0, 4'd3, 1'b1, 1'b0, 4'd4);
        cdb_valid = 2'b10;  cdb_tag = {4'd3, 4'd0};  cdb_value = {32'hDEADBEEF, 32'h0};
        tick();
        cdb_valid = 2'b00;
        chk("sw_st_early", 32'(st_ready), 32'd0);
        tick();
        chk("sw_st_ready", 32'(st_ready), 32'd1);
        chk("sw_st_rob", 32'(st_rob), 32'd4);
        tick();
        chk("sw_st_once", 32'(st_ready), 32'd0);
        chk("sw_hold", 32'(mem_req), 32'd0);
        commit(4'd4);
        tick();
        chk("sw_req", 32'(mem_req), 32'd1);
        chk("sw_we", 32'(mem_we), 32'd1);
        chk("sw_addr", mem_addr, 32'h200);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_width", 32'(mem_width), 32'd4);
        ack();
        chk("sw_done", 32'(mem_req), 32'd0);

        // SH: data masked to 16 bits; port 0 carries an unrelated tag
        enq(SH, 32'h210, 32'h0, 32'h0, 4'd0, 4'd3, 1'b1, 1'b0, 4'd5);
        cdb_valid = 2'b11;  cdb_tag = {4'd3, 4'd7};  cdb_value = {32'hDEADBEEF, 32'h12345678};
        tick();
        cdb_valid = 2'b00;
        tick();
        chk("sh_st_ready", 32'(st_ready), 32'd1);
        chk("sh_st_rob", 32'(st_rob), 32'd5);
        commit(4'd5);
        wait_req("sh_req");
        chk("sh_wdata", mem_wdata, 32'h0000BEEF);
        chk("sh_width", 32'(mem_width), 32'd2);
        ack();

        // Fill from head=4 so the queue wraps; extra enqueue while full is dropped
        for (int i = 0; i < 8; i++)
            enq(SW, 32'h1000 + 32'(4 * i), 32'(i), 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'(i));
        chk("fill_full", 32'(lsq_full), 32'd1);
        enq(SW, 32'h2000, 32'h99, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd9);
        chk("fill_ignored", 32'(lsq_full), 32'd1);
        commit(4'd0);
        wait_req("fill_req0");
        chk("fill_addr0", mem_addr, 32'h1000);
        ack();
        chk("fill_pop", 32'(lsq_full), 32'd0);
        enq(SW, 32'h1020, 32'd8, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd10);
        chk("fill_refull", 32'(lsq_full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            commit((i == 8) ? 4'd10 : 4'(i));
            wait_req("fill_req");
            chk("fill_addr", mem_addr, 32'h1000 + 32'(4 * i));
            chk("fill_wdata", mem_wdata, 32'(i));
            ack();
        end
        chk("fill_empty", 32'(lsq_full), 32'd0);

        // MMIO load waits for rob_head
        rob_head = 4'd2;
        enq(LW, 32'h30000, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd6);
        tick(); tick();
        chk("mmio_block", 32'(mem_req), 32'd0);
        rob_head = 4'd6;
        tick();
        chk("mmio_req", 32'(mem_req), 32'd1);
        chk("mmio_addr", mem_addr, 32'h30000);
        rob_head = 4'd0;
        ack();
        rdata(32'h12345678);
        chk("mmio_val", ld_value, 32'h12345678);
        chk("mmio_rob", 32'(ld_rob), 32'd6);

        // Flush with a load in WAIT: returned data is discarded
        enq(LW, 32'h500, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd7);
        tick();
        chk("flw_req", 32'(mem_req), 32'd1);
        ack();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rdata(32'h55);
        chk("flw_noldv", 32'(ld_valid), 32'd0);
        tick();
        chk("flw_noldv2", 32'(ld_valid), 32'd0);
        chk("flw_idle", 32'(mem_req), 32'd0);

        // Flush with a load in REQ and no ack: request drops next cycle
        enq(LW, 32'h540, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd8);
        tick();
        chk("flr_req", 32'(mem_req), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flr_drop", 32'(mem_req), 32'd0);
        tick(); tick();
        chk("flr_gone", 32'(mem_req), 32'd0);

        // Flush+commit together: SW survives, two loads behind it are dropped
        enq(SW, 32'h600, 32'hCAFEF00D, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1);
        enq(LW, 32'h700, 32'h0, 32'h0, 4'd9, 4'd0, 1'b0, 1'b1, 4'd2);
        enq(LW, 32'h700, 32'h0, 32'h4, 4'd9, 4'd0, 1'b0, 1'b1, 4'd3);
        flush = 1'b1;  commit_valid = 1'b1;  commit_rob = 4'd1;
        tick();
        flush = 1'b0;  commit_valid = 1'b0;
        wait_req("fls_req");
        chk("fls_we", 32'(mem_we), 32'd1);
        chk("fls_addr", mem_addr, 32'h600);
        chk("fls_wdata", mem_wdata, 32'hCAFEF00D);
        ack();
        cdb_valid = 2'b01;  cdb_tag = {4'd0, 4'd9};  cdb_value = 64'h0;
        tick();
        cdb_valid = 2'b00;
        tick(); tick();
        chk("fls_loads_gone", 32'(mem_req), 32'd0);
        enq(LW, 32'h800, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd4);
        tick();
        chk("fls_tail_req", 32'(mem_req), 32'd1);
        chk("fls_tail_addr", mem_addr, 32'h800);
        ack();
        rdata(32'hA5A5A5A5);
        chk("fls_tail_val", ld_value, 32'hA5A5A5A5);

        // Load-to-load bypass through the internal result port
        enq(LW, 32'h900, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd5);
        enq(LH, 32'h0, 32'h0, 32'd2, 4'd5, 4'd0, 1'b0, 1'b1, 4'd6);
        chk("byp_req1", 32'(mem_req), 32'd1);
        chk("byp_addr1", mem_addr, 32'h900);
        ack();
        rdata(32'h00000A00);
        chk("byp_ldv1", 32'(ld_valid), 32'd1);
        chk("byp_val1", ld_value, 32'h00000A00);
        tick();
        chk("byp_capture", 32'(mem_req), 32'd0);
        tick();
        chk("byp_req2", 32'(mem_req), 32'd1);
        chk("byp_addr2", mem_addr, 32'hA02);
        chk("byp_width2", 32'(mem_width), 32'd2);
        ack();
        rdata(32'h00008001);
        chk("byp_val2", ld_value, 32'hFFFF8001);
        chk("byp_rob2", 32'(ld_rob), 32'd6);

        // Reset during a request: outstanding data is ignored
        enq(LW, 32'hA00, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd3);
        tick();
        chk("rstm_req", 32'(mem_req), 32'd1);
        rst_in = 1'b1;  mem_ack = 1'b1;
        tick();
        rst_in = 1'b0;  mem_ack = 1'b0;
        chk("rstm_req_low", 32'(mem_req), 32'd0);
        rdata(32'h77);
        chk("rstm_noldv", 32'(ld_valid), 32'd0);
        tick();
        chk("rstm_idle", 32'(mem_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsq_commit.md
# lsq_commit

Parametrised load/store queue between dispatch and the memory controller; successor to the single-channel LSB. Adds configurable depth and ROB tag width, N common-data-bus (CDB) snoop ports plus an internal load-result bypass, and an early "store ready" report to the ROB. Stores drain only after ROB commit, and committed stores survive a pipeline flush.

## Interface
- DEPTH, 8, queue entries (power of 2, ≥2)
- ROB_BITS, 4, ROB tag width
- CDB_PORTS, 2, external broadcast ports
- MMIO_BASE, 32'h00030000, loads at addr ≥ MMIO_BASE are non-speculative
- clk_in  in  1  clock
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global ready; low freezes all state and outputs
- lsq_full  out  1  count == DEPTH
- enq_valid  in  1  dispatch entry
- enq_op  in  6  10 LB, 11 LH, 12 LW, 13 LBU, 14 LHU, 15 SB, 16 SH, 17 SW
- enq_vj, enq_vk, enq_imm  in  32 each  base, store data, offset
- enq_qj, enq_qk  in  ROB_BITS each  producer tags
- enq_j, enq_k  in  1 each  operand already valid
- enq_rob  in  ROB_BITS  own ROB tag
- cdb_valid  in  CDB_PORTS  broadcast strobes
- cdb_tag  in  CDB_PORTS*ROB_BITS  packed tags, port p at [p*ROB_BITS +: ROB_BITS]
- cdb_value  in  CDB_PORTS*32  packed values
- rob_head  in  ROB_BITS  oldest ROB tag
- commit_valid, commit_rob  in  1, ROB_BITS  ROB commits a store
- flush  in  1  mispredict clear
- mem_req, mem_we  out  1 each  request, 1 = store
- mem_width  out  3  bytes: 1/2/4
- mem_addr, mem_wdata  out  32 each
- mem_ack  in  1  request accepted
- mem_rvalid, mem_rdata  in  1, 32  load data return
- ld_valid, ld_rob, ld_value  out  1, ROB_BITS, 32  load result to CDB
- st_ready, st_rob  out  1, ROB_BITS  store operands resolved

## Operation
- Circular queue; head/tail ptrs log2(DEPTH) bits wrap DEPTH-1→0; count log2(DEPTH)+1 bits.
- Enqueue when enq_valid && !lsq_full; enq_valid while full is ignored, no state change. lsq_full uses pre-cycle count: same-cycle pop does not admit an enqueue when full.
- Snoop sources: CDB ports 0..CDB_PORTS-1, then internal port = registered ld_valid/ld_rob/ld_value. Each busy entry with !j (!k) and qj (qk) equal to a valid source tag captures value, sets flag; lowest-numbered source wins on duplicates. Enqueuing entry snoops the same sources in its enqueue cycle.
- Store report: each store entry whose j&&k are set and not yet reported raises st_ready once, oldest first, one per cycle; entry marked reported.
- commit_valid: busy store with rob == commit_rob marked committed. Committed stores are always a prefix starting at head.
- Head FSM IDLE/REQ/WAIT/DRAIN:
  - IDLE: head busy, j&&k. addr = vj+imm mod 2^32. Load issues if addr < MMIO_BASE or rob_head == rob. Store issues only when committed. Issue → REQ.
  - REQ: mem_req=1, outputs stable until mem_ack. Store ack: pop head → IDLE. Load ack → WAIT.
  - WAIT: on mem_rvalid pop head; ld_value = sign-ext (LB/LH), zero-ext (LBU/LHU), or raw (LW); ld_valid=1 → IDLE.
  - DRAIN: await mem_rvalid, discard, → IDLE.
- Store mem_wdata = vk masked to 8/16/32 bits.
- Flush: drop all uncommitted entries; tail = head + committed count; reported/snoop state of survivors kept. FSM: REQ on committed store continues. REQ on load with no ack → IDLE, mem_req low next cycle. REQ load with ack in flush cycle → DRAIN. WAIT → DRAIN. Flush and enqueue together: flush wins. Flush and commit together: commit applied first.
- rdy_in low: no register changes; ack/rvalid arriving then are not sampled (memctrl shares rdy_in).

## Timing
- Reset: ptrs, count, all busy/committed/reported = 0; FSM IDLE; mem_req, mem_we, ld_valid, st_ready, lsq_full = 0; data outputs 0.
- ld_valid/st_ready are single-cycle registered pulses.
- Load hit path: IDLE→REQ 1 cycle after operands ready; ld_valid the cycle after mem_rvalid.
- Entry becomes issuable the cycle after its last operand's broadcast.
- Reset mid-request returns all to reset state; outstanding memory data ignored.

## Test plan
- Basic load: enqueue LB, vj=0x100, imm=4, j=k=1; mem_rdata=0x80 → mem_addr 0x104, width 1; ld_value 0xFFFFFF80. Same with LBU → 0x00000080.
- Wake-up: SW with qk=3 pending, CDB port 1 broadcasts tag 3 value 0xDEADBEEF → st_ready st_rob once; after commit_valid, mem_we=1, wdata 0xDEADBEEF; SH variant → wdata 0x0000BEEF.
- Fill DEPTH entries → lsq_full=1, extra enq ignored; wrap past DEPTH-1; count correct after mixed enqueue/pop.
- MMIO: load addr 0x30000, rob_head≠rob → no mem_req; rob_head set equal → mem_req next cycle.
- Flush with committed SW at head, two uncommitted loads, load in WAIT → SW still drains; loads gone; returned data gives no ld_valid; tail = head+1.
- Load→load bypass: second load's qj = first load's rob → captures ld_value in same cycle ld_valid is high, issues next cycle.
